apb_cmd_master: RTL

//  Synthesizable, parametrised APB4 master for the ap409 APB subsystem.
//  - Accepts one command at a time on a valid/ready request port.
//  - Runs the APB setup/access sequence and returns status and read data on a valid/ready response port.
//  - Adds over the task-based master: PSTRB, PSLVERR capture, wait-state timeout with abort, response backpressure.
//

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_wait_timer.sv | 62 ++++++
 rtl/apb_cmd_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types for the APB command master. This package holds
//               the bus-phase state encoding, the response error codes and
//               the error field width.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ERR_W = 2;

    // Each state matches the APB bus phase that is visible in the same cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef enum logic [APB_ERR_W-1:0] {
        APB_OK      = 2'd0,
        APB_SLVERR  = 2'd1,
        APB_TIMEOUT = 2'd2
    } apb_err_e;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Saturating counter of ACCESS cycles in which pready is low.
//               expired_o is high when the increment in the current cycle
//               reaches TIMEOUT. An abort therefore happens after exactly
//               TIMEOUT wait cycles. If TIMEOUT is 0, expired_o is tied low.
// Ports       : clk_i     - clock
//               rst_ni    - synchronous active-low reset
//               clear_i   - clear the counter (new transfer)
//               inc_i     - count one wait cycle
//               expired_o - this wait cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_ni, clear_i, inc_i};
            assign expired_o     = 1'b0;
        end else begin : g_timeout
            localparam int               CNT_W    = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (inc_i && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // The counter holds the wait cycles seen before this one, so the
            // limit is reached when the current cycle is number TIMEOUT.
            assign expired_o = (cnt_q >= CNT_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_master
// Description : APB4 master. It takes one command at a time on a valid/ready
//               request port and runs the SETUP and ACCESS phases. It returns
//               read data and status on a valid/ready response port.
//               Supported features are PSTRB, PSLVERR capture, a wait-state
//               timeout with abort, and response backpressure.
// Ports       : pclk_i, presetn_i         - clock, synchronous active-low reset
//               cmd_*                     - command request (valid/ready)
//               rsp_*                     - response (valid/ready)
//               paddr_o .. pstrb_o        - APB requester outputs
//               prdata_i, pready_i,
//               pslverr_i                 - APB completer inputs
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk_i,
    input  logic                presetn_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output apb_err_e            rsp_err_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic [DATA_W/8-1:0] pstrb_o,
    input  logic [DATA_W-1:0]   prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e          state_q,     state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    apb_err_e            rsp_err_q,   rsp_err_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic [STRB_W-1:0]   pstrb_q,     pstrb_d;

    logic cmd_accept;
    logic timer_clear;
    logic timer_inc;
    logic timer_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (pclk_i),
        .rst_ni    (presetn_i),
        .clear_i   (timer_clear),
        .inc_i     (timer_inc),
        .expired_o (timer_expired)
    );

    // cmd_ready is a register. It stays low for one cycle after reset and
    // low in every state except IDLE.
    assign cmd_accept = (state_q == IDLE) && cmd_ready_q && cmd_valid_i;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d     = SETUP;
                    paddr_d     = cmd_addr_i;
                    pwrite_d    = cmd_write_i;
                    pwdata_d    = cmd_wdata_i;
                    pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
                    timer_clear = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // Completion has priority over the timeout. This matters
                // when pready arrives in the last allowed cycle.
                if (pready_i) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i ? APB_SLVERR : APB_OK;
                    rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expired) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = APB_TIMEOUT;
                        rsp_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear the write-side bus signals when the transfer ends. paddr
        // keeps its last value.
        if ((state_q == ACCESS) && (state_d == RESP)) begin
            pwrite_d = 1'b0;
            pwdata_d = '0;
            pstrb_d  = '0;
        end

        // All bus and handshake outputs are registered. They are derived
        // from the next state, so they match the phase in the same cycle.
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= APB_OK;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign paddr_o     = paddr_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;

endmodule
`default_nettype wire
